// File: rtl/div_issue_unit.sv
// div_issue_unit: execute-stage front end for a multi-cycle unsigned divider.
// Takes RISC-V DIV/DIVU/REM/REMU requests and resolves divide-by-zero and signed
// overflow locally. Other requests go to the divider as operand magnitudes, and the
// unit applies the sign fix-up to the quotient or remainder.
// Handshakes: a transfer happens on a rising clock edge where valid and ready are
// both high. A valid holds its payload until that edge. A ready may depend on the
// current state only (req_ready additionally masks flush).
module div_issue_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             div_start,
    output logic [XLEN-1:0]  div_numerator,
    output logic [XLEN-1:0]  div_denominator,
    input  logic             div_rdy,
    output logic             div_result_rdy,
    input  logic             div_valid,
    input  logic [XLEN-1:0]  div_quotient,
    input  logic [XLEN-1:0]  div_remainder,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FIX   = 3'd3,
        S_RESP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t           state;
    logic             idle_q;
    logic [1:0]       op_q;
    logic             sq_q;
    logic             sr_q;
    logic [XLEN-1:0]  q_q;
    logic [XLEN-1:0]  r_q;

    // Request decode: signedness, operand magnitudes and the two locally resolved cases.
    logic             is_signed;
    logic             neg1;
    logic             neg2;
    logic [XLEN-1:0]  mag1;
    logic [XLEN-1:0]  mag2;
    logic             div_zero;
    logic             overflow;
    logic [XLEN-1:0]  special_data;
    logic [XLEN-1:0]  fixed_q;
    logic [XLEN-1:0]  fixed_r;

    assign is_signed = ~req_op[0];
    assign neg1      = is_signed & req_rs1[XLEN-1];
    assign neg2      = is_signed & req_rs2[XLEN-1];
    // |MIN_NEG| wraps back to MIN_NEG, which is the correct unsigned magnitude.
    assign mag1      = neg1 ? -req_rs1 : req_rs1;
    assign mag2      = neg2 ? -req_rs2 : req_rs2;
    assign div_zero  = (req_rs2 == '0);
    assign overflow  = is_signed & (req_rs1 == MIN_NEG) & (req_rs2 == ALL_ONE);

    // Divide by zero: quotient all ones, remainder = dividend. Overflow: quotient = dividend, remainder 0.
    always_comb begin
        special_data = '0;
        if (div_zero) begin
            special_data = req_op[1] ? req_rs1 : ALL_ONE;
        end else begin
            special_data = req_op[1] ? '0 : req_rs1;
        end
    end

    assign fixed_q   = sq_q ? -q_q : q_q;
    assign fixed_r   = sr_q ? -r_q : r_q;

    assign req_ready = idle_q & ~flush;
    assign dbg_state = state;

    // Control FSM together with the operand, result and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            idle_q          <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_tag         <= '0;
            div_start       <= 1'b0;
            div_result_rdy  <= 1'b0;
            div_numerator   <= '0;
            div_denominator <= '0;
            op_q            <= '0;
            sq_q            <= 1'b0;
            sr_q            <= 1'b0;
            q_q             <= '0;
            r_q             <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        idle_q  <= 1'b0;
                        rsp_tag <= req_tag;
                        if (div_zero || overflow) begin
                            rsp_data  <= special_data;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            div_numerator   <= mag1;
                            div_denominator <= mag2;
                            op_q            <= req_op;
                            sq_q            <= neg1 ^ neg2;
                            sr_q            <= neg1;
                            div_start       <= 1'b1;
                            state           <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (div_rdy) begin
                        // The divider takes start on this edge; a flush now must drain it.
                        div_start      <= 1'b0;
                        div_result_rdy <= 1'b1;
                        state          <= flush ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        div_start <= 1'b0;
                        idle_q    <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (div_valid) begin
                        div_result_rdy <= 1'b0;
                        q_q            <= div_quotient;
                        r_q            <= div_remainder;
                        if (flush) begin
                            // The result arrives with the flush: the divider is idle again.
                            idle_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_FIX;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        idle_q <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        rsp_data  <= op_q[1] ? fixed_r : fixed_q;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (flush || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        idle_q    <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (div_valid) begin
                        div_result_rdy <= 1'b0;
                        idle_q         <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid      <= 1'b0;
                    div_start      <= 1'b0;
                    div_result_rdy <= 1'b0;
                    idle_q         <= 1'b1;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_unit.sv
// Testbench for div_issue_unit with a behavioural model of the unsigned divider.
module tb_div_issue_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONE = 32'hFFFF_FFFF;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [XLEN-1:0]  req_rs1 = '0;
    logic [XLEN-1:0]  req_rs2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [XLEN-1:0]  rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             div_start;
    logic [XLEN-1:0]  div_numerator;
    logic [XLEN-1:0]  div_denominator;
    logic             div_rdy;
    logic             div_result_rdy;
    logic             div_valid;
    logic [XLEN-1:0]  div_quotient;
    logic [XLEN-1:0]  div_remainder;
    logic [2:0]       dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [XLEN-1:0] exp_q[$];

    div_issue_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .div_start(div_start), .div_numerator(div_numerator), .div_denominator(div_denominator),
        .div_rdy(div_rdy), .div_result_rdy(div_result_rdy), .div_valid(div_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Divider model: idle -> busy -> output (parks until ready_i) -> one-cycle valid.
    // The start edge loads the operands and counts as the first iteration cycle.
    int dphase = 0;
    int dcnt = 0;
    logic [XLEN-1:0] dq = '0;
    logic [XLEN-1:0] dr = '0;
    int start_cnt = 0;
    int valid_cnt = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            dphase <= 0;
            dcnt   <= 0;
        end else begin
            case (dphase)
                0: if (div_start) begin
                    dphase    <= 1;
                    dcnt      <= XLEN - 1;
                    start_cnt <= start_cnt + 1;
                    dq <= (div_denominator == 0) ? ALL_ONE : div_numerator / div_denominator;
                    dr <= (div_denominator == 0) ? div_numerator : div_numerator % div_denominator;
                end
                1: begin
                    dcnt <= dcnt - 1;
                    if (dcnt == 1) dphase <= 2;
                end
                2: if (div_result_rdy) dphase <= 3;
                default: begin
                    dphase    <= 0;
                    valid_cnt <= valid_cnt + 1;
                end
            endcase
        end
    end

    assign div_rdy       = (dphase == 0);
    assign div_valid     = (dphase == 3);
    assign div_quotient  = dq;
    assign div_remainder = dr;

    // Reference model: RISC-V M-extension division semantics from plain arithmetic.
    function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic signed [XLEN-1:0] sres;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                if (b == 0) return ALL_ONE;
                if (a == MIN_NEG && b == ALL_ONE) return a;
                sres = sa / sb;
                return sres;
            end
            2'b01: return (b == 0) ? ALL_ONE : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == ALL_ONE) return '0;
                sres = sa % sb;
                return sres;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        return (b == 0) || (!op[0] && a == MIN_NEG && b == ALL_ONE);
    endfunction

    function automatic logic [XLEN-1:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return MIN_NEG;
            2: return ALL_ONE;
            3: return XLEN'($urandom_range(0, 20));
            4: return -XLEN'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Driver: wait for req_ready, present one request, then check response timing,
    // payload, stability while rsp_ready is held low, and the handshake.
    task automatic run_req(input logic [1:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                           input int hold);
        int n;
        int acc_edge;
        int lat;
        int s0;
        bit spec;
        logic [XLEN-1:0] exp;
        spec = is_special(op, a, b);
        exp_q.push_back(ref_result(op, a, b));
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_timeout", req_ready, 1);
        acc_edge = cyc + 1;
        s0 = start_cnt;
        @(negedge clock);
        req_valid = 1'b0;
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("rsp_valid_timeout", rsp_valid, 1);
        lat = cyc - acc_edge + 1;
        chk("latency", lat, spec ? 1 : XLEN + 4);
        exp = exp_q.pop_front();
        chk("rsp_data", rsp_data, exp);
        chk("rsp_tag", rsp_tag, tag);
        if (spec) chk("special_no_div_start", start_cnt - s0, 0);
        else      chk("normal_one_div_start", start_cnt - s0, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_data", rsp_data, exp);
            chk("hold_rsp_tag", rsp_tag, tag);
            chk("hold_div_idle", div_rdy, 1);
            chk("hold_result_rdy_low", div_result_rdy, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        int n;
        int v0;
        logic [1:0] rop;

        // reset state
        #12;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        chk("reset_div_start", div_start, 0);
        chk("reset_result_rdy", div_result_rdy, 0);
        @(negedge clock);
        reset = 1'b1;

        // basic unsigned
        run_req(2'b01, 32'd100, 32'd7, 5'd3, 0);
        run_req(2'b11, 32'd100, 32'd7, 5'd4, 0);

        // signed fix-up
        run_req(2'b00, -32'sd7, 32'd2, 5'd5, 0);
        run_req(2'b10, -32'sd7, 32'd2, 5'd6, 0);
        run_req(2'b10, 32'd7, -32'sd2, 5'd7, 0);
        run_req(2'b00, 32'd7, -32'sd2, 5'd8, 0);

        // divide by zero
        run_req(2'b00, 32'h1234_5678, 32'd0, 5'd9, 0);
        run_req(2'b11, 32'd5, 32'd0, 5'd10, 0);

        // overflow and the most negative dividend
        run_req(2'b00, MIN_NEG, ALL_ONE, 5'd11, 0);
        run_req(2'b10, MIN_NEG, ALL_ONE, 5'd12, 0);
        run_req(2'b01, MIN_NEG, 32'd2, 5'd13, 0);

        // flush in WAIT: no response, drain until the divider pulses valid
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_rs1   = 32'hFFFF_0000;
        req_rs2   = 32'd17;
        req_tag   = 5'd14;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (11) @(negedge clock);
        v0 = valid_cnt;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin
            chk("drain_no_rsp", rsp_valid, 0);
            @(negedge clock);
            n++;
        end
        chk("drain_req_ready_timeout", req_ready, 1);
        chk("drain_waited_for_valid", valid_cnt - v0, 1);
        chk("drain_no_rsp_end", rsp_valid, 0);
        run_req(2'b01, 32'd9, 32'd3, 5'd15, 0);

        // back-pressure on the response
        run_req(2'b00, -32'sd100, 32'd7, 5'd16, 5);

        // randomized requests
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            run_req(rop, rand_operand(), rand_operand(), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3));
        end

        // asynchronous reset while the divider works
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd1000;
        req_rs2   = 32'd3;
        req_tag   = 5'd21;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("areset_req_ready", req_ready, 1);
        chk("areset_rsp_valid", rsp_valid, 0);
        chk("areset_rsp_data", rsp_data, 0);
        chk("areset_rsp_tag", rsp_tag, 0);
        chk("areset_div_start", div_start, 0);
        chk("areset_result_rdy", div_result_rdy, 0);
        chk("areset_numerator", div_numerator, 0);
        @(negedge clock);
        reset = 1'b1;
        run_req(2'b10, 32'd1000, 32'd3, 5'd22, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
